// File: rtl/inv_sequencer_pkg.sv
// Shared constants for the field-inversion sequencer: modulus, exponent,
// ALU op codes, sequencer state encodings and watchdog default.
package inv_sequencer_pkg;

    localparam logic [254:0] Q   = ~255'd18;
    localparam logic [254:0] EXP = Q - 255'd2;

    localparam logic [1:0] ALU_PRE_CAL = 2'd0;
    localparam logic [1:0] ALU_DOUBLE  = 2'd1;
    localparam logic [1:0] ALU_DIVINV  = 2'd2;
    localparam logic [1:0] ALU_DIVMUL  = 2'd3;

    typedef logic [2:0] seq_state_t;
    localparam seq_state_t S_IDLE  = 3'd0;
    localparam seq_state_t S_ISSUE = 3'd1;
    localparam seq_state_t S_RUN   = 3'd2;
    localparam seq_state_t S_DRAIN = 3'd3;
    localparam seq_state_t S_FIN   = 3'd4;

    localparam int unsigned WDOG_DEFAULT = 7;

    // Bit 254 is consumed when the base is copied into the LUT.
    localparam logic [7:0] BIT_TOP = 8'd253;

endpackage

// File: rtl/inv_sequencer.sv
// Drives the ALU DIVINV op through left-to-right square-and-multiply over
// EXP[253:0], with abort draining and a watchdog on the ALU ready strobe.
module inv_sequencer
    import inv_sequencer_pkg::*;
#(
    parameter int unsigned WDOG = WDOG_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       alu_ready,
    output logic       alu_valid,
    output logic [1:0] alu_state,
    output logic       alu_keep_flag,
    output logic       alu_consecutive_flag,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] bit_idx
);

    localparam int unsigned    WDW      = $clog2(WDOG + 2);
    localparam logic [WDW-1:0] WDOG_LIM = WDW'(WDOG);

    seq_state_t     state_q, state_d;
    logic [7:0]     bit_idx_q, bit_idx_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           err_q, err_d;
    logic           wdog_exp;
    logic           active;

    assign wdog_exp = (wdog_q > WDOG_LIM);

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        wdog_d    = wdog_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ISSUE;
                    bit_idx_d = BIT_TOP;
                    wdog_d    = '0;
                    err_d     = 1'b0;
                end
            end
            S_ISSUE: begin
                state_d = abort ? S_DRAIN : S_RUN;
                wdog_d  = '0;
            end
            S_RUN: begin
                if (wdog_exp) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else if (alu_ready) begin
                    // Last bit wins over a coincident abort: result is complete.
                    if (bit_idx_q == 8'd0) begin
                        state_d = S_FIN;
                        err_d   = 1'b0;
                    end else if (abort) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q - 8'd1;
                        wdog_d    = '0;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (abort) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (wdog_exp || alu_ready) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                wdog_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                wdog_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        active    = (state_q == S_ISSUE) || (state_q == S_RUN) || (state_q == S_DRAIN);
        busy      = active;
        alu_valid = (state_q == S_ISSUE);
        alu_state = active ? ALU_DIVINV : ALU_PRE_CAL;
        // DRAIN keeps the bit flag so the in-flight op runs its full length.
        alu_consecutive_flag = active & EXP[bit_idx_q];
        alu_keep_flag = ((state_q == S_ISSUE) || (state_q == S_RUN)) &&
                        (bit_idx_q != 8'd0) && !abort && !wdog_exp;
        done    = (state_q == S_FIN);
        err     = (state_q == S_FIN) & err_q;
        bit_idx = bit_idx_q;
    end

endmodule
